// File: rtl/maxunpool_stream.sv
// maxunpool_stream: 2x2 max-unpool of a raster stream; the bottom row of each
// window is replayed from a one-row line buffer holding {data, idx}.
module maxunpool_stream #(
  parameter int DATA_W = 16,
  parameter int IN_DIM = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done
);
  localparam int CW = $clog2(IN_DIM);
  typedef enum logic [1:0] {S_TOP_L, S_TOP_R, S_BOT_L, S_BOT_R} state_t;
  state_t state, state_n;
  logic [CW-1:0] col, col_n, row, row_n;
  logic [DATA_W-1:0] cur_data, out_data_n;
  logic [1:0] cur_idx;
  logic [DATA_W+1:0] line_buf [IN_DIM];
  logic [DATA_W+1:0] lb;
  logic out_valid_n, out_last_n, adv, take, col_end, row_end;
  assign adv = !out_valid || out_ready;
  assign in_ready = (state == S_TOP_L) && adv;
  assign take = in_ready && in_valid;
  assign frame_done = out_valid && out_ready && out_last;
  assign col_end = col == CW'(IN_DIM - 1);
  assign row_end = row == CW'(IN_DIM - 1);
  assign lb = line_buf[col];
  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    out_valid_n = out_valid;
    out_data_n = out_data;
    out_last_n = out_last;
    if (adv) begin
      out_valid_n = 1'b1;
      out_last_n = 1'b0;
      case (state)
        S_TOP_L: begin
          out_valid_n = in_valid;
          out_data_n = in_valid ? (in_idx == 2'd0 ? in_data : '0) : out_data;
          state_n = in_valid ? S_TOP_R : S_TOP_L;
        end
        S_TOP_R: begin
          out_data_n = cur_idx == 2'd1 ? cur_data : '0;
          col_n = col_end ? '0 : col + 1'b1;
          state_n = col_end ? S_BOT_L : S_TOP_L;
        end
        S_BOT_L: begin
          out_data_n = lb[1:0] == 2'd2 ? lb[DATA_W+1:2] : '0;
          state_n = S_BOT_R;
        end
        default: begin
          out_data_n = lb[1:0] == 2'd3 ? lb[DATA_W+1:2] : '0;
          out_last_n = col_end && row_end;
          col_n = col_end ? '0 : col + 1'b1;
          row_n = !col_end ? row : (row_end ? '0 : row + 1'b1);
          state_n = col_end ? S_TOP_L : S_BOT_L;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_TOP_L;
      col <= '0;
      row <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      cur_data <= '0;
      cur_idx <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      out_valid <= out_valid_n;
      out_data <= out_data_n;
      out_last <= out_last_n;
      if (take) {cur_data, cur_idx} <= {in_data, in_idx};
    end
  end
  // line buffer needs no reset: every entry is written before its replay
  always_ff @(posedge clk) begin
    if (take) line_buf[col] <= {in_data, in_idx};
  end
endmodule

// File: tb/tb_maxunpool_stream.sv
// tb_maxunpool_stream: randomized stream bench for maxunpool_stream against a
// reference that maps each output (y,x) straight from pooled (y/2,x/2).
module tb_maxunpool_stream;
  localparam int DW = 16, N = 14, M = 28, FR = 784, NE = 196;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_last, frame_done;
  logic [DW-1:0] in_data = 0, out_data;
  logic [1:0] in_idx = 0;
  int errors = 0, checks = 0;
  logic [DW-1:0] pd [2*NE];
  logic [1:0] pi [2*NE];
  logic [DW-1:0] cap_d[$];
  bit cap_l[$];
  int cap_t[$];
  int acc_t [2*NE];
  int fd_cnt, stall_viol, acc_viol, cyc;
  bit timed_out;

  always #5 clk = ~clk;

  maxunpool_stream #(.DATA_W(DW), .IN_DIM(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_idx(in_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_done(frame_done)
  );

  function automatic logic [DW-1:0] ref_out(int n);
    int p = n % FR;
    int y = p / M;
    int x = p % M;
    int e = (n / FR) * NE + (y / 2) * N + x / 2;
    return int'(pi[e]) == 2 * (y % 2) + (x % 2) ? pd[e] : '0;
  endfunction

  task automatic fill_random(int n);
    for (int i = 0; i < n; i++) begin
      pd[i] = DW'($urandom);
      pi[i] = 2'($urandom);
    end
  endtask

  // Drive nel inputs and capture beats until max_beats, sampling at negedge.
  task automatic stream(int nel, int max_beats, int rpct, int vpct);
    int k = 0;
    bit acc, tr, ps = 0, pl = 0;
    logic [DW-1:0] pdd = '0;
    cap_d.delete(); cap_l.delete(); cap_t.delete();
    fd_cnt = 0; stall_viol = 0; acc_viol = 0; timed_out = 0; cyc = 0;
    @(posedge clk); #1;
    in_data = pd[0]; in_idx = pi[0];
    in_valid = $urandom_range(99) < vpct;
    out_ready = $urandom_range(99) < rpct;
    while (1) begin
      @(negedge clk);
      cyc++;
      acc = in_valid && in_ready;
      tr = out_valid && out_ready;
      if (acc) begin
        acc_t[k] = cyc;
        if (cap_d.size() + int'(out_valid) != (k / NE) * FR + ((k % NE) / N) * 2 * M + ((k % NE) % N) * 2)
          acc_viol++;
      end
      if (ps && (!out_valid || out_data !== pdd || out_last !== pl)) stall_viol++;
      ps = out_valid && !out_ready;
      pdd = out_data;
      pl = out_last;
      if (frame_done) fd_cnt++;
      if (tr) begin
        cap_d.push_back(out_data);
        cap_l.push_back(out_last);
        cap_t.push_back(cyc);
      end
      if (cyc > 20000) timed_out = 1;
      if (cap_d.size() >= max_beats || timed_out) break;
      @(posedge clk); #1;
      if (acc) k++;
      if (k < nel) begin
        in_data = pd[k]; in_idx = pi[k];
        in_valid = $urandom_range(99) < vpct;
      end else in_valid = 0;
      out_ready = $urandom_range(99) < rpct;
    end
    in_valid = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    rst = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_frame;
    int nz = 0, nl = 0;
    for (int i = 0; i < NE; i++) begin pd[i] = DW'(i + 1); pi[i] = 2'd0; end
    stream(NE, FR, 100, 100);
    checks++; if (cap_d.size() != FR) begin errors++; $display("FAIL seq_beats: got %0d want %0d", cap_d.size(), FR); end
    for (int n = 0; n < cap_d.size(); n++) begin
      checks++; if (cap_d[n] !== ref_out(n)) begin errors++; $display("FAIL seq_map[%0d]: got %h want %h", n, cap_d[n], ref_out(n)); end
      if (cap_d[n] != 0) nz++;
      if (cap_l[n]) nl++;
    end
    if (cap_d.size() != FR) return;
    checks++; if (cap_d[0] !== 16'd1) begin errors++; $display("FAIL seq_0_0: got %h want 1", cap_d[0]); end
    checks++; if (cap_d[1] !== 16'd0) begin errors++; $display("FAIL seq_0_1: got %h want 0", cap_d[1]); end
    checks++; if (cap_d[M] !== 16'd0) begin errors++; $display("FAIL seq_1_0: got %h want 0", cap_d[M]); end
    checks++; if (cap_d[2] !== 16'd2) begin errors++; $display("FAIL seq_0_2: got %h want 2", cap_d[2]); end
    checks++; if (cap_d[26*M+26] !== 16'd196) begin errors++; $display("FAIL seq_26_26: got %h want c4", cap_d[26*M+26]); end
    checks++; if (nz != NE) begin errors++; $display("FAIL seq_nonzero: got %0d want %0d", nz, NE); end
    checks++; if (nl != 1 || !cap_l[FR-1]) begin errors++; $display("FAIL seq_last: got count %0d final %b want 1 1", nl, cap_l[FR-1]); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL seq_frame_done: got %0d want 1", fd_cnt); end
    checks++; if (cap_t[FR-1] - cap_t[0] != FR - 1) begin errors++; $display("FAIL seq_throughput: got %0d want %0d", cap_t[FR-1] - cap_t[0], FR - 1); end
    checks++; if (acc_viol != 0) begin errors++; $display("FAIL seq_accept_slot: got %0d want 0", acc_viol); end
  endtask

  task automatic test_idx_cycle;
    int pos [4] = '{0, 1, M, M + 1};
    for (int f = 0; f < 4; f++) begin
      fill_random(NE);
      pd[0] = 16'h1234;
      pi[0] = 2'(f);
      stream(NE, FR, 100, 100);
      checks++; if (cap_d.size() != FR) begin errors++; $display("FAIL idx%0d_beats: got %0d want %0d", f, cap_d.size(), FR); end
      if (cap_d.size() != FR) continue;
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (cap_d[pos[j]] !== (j == f ? 16'h1234 : 16'h0)) begin
          errors++; $display("FAIL idx%0d_pos%0d: got %h want %h", f, j, cap_d[pos[j]], j == f ? 16'h1234 : 16'h0);
        end
      end
    end
  endtask

  task automatic test_random_stall;
    fill_random(NE);
    stream(NE, FR, 50, 80);
    checks++; if (timed_out || cap_d.size() != FR) begin errors++; $display("FAIL stall_beats: got %0d want %0d", cap_d.size(), FR); end
    for (int n = 0; n < cap_d.size(); n++) begin
      checks++; if (cap_d[n] !== ref_out(n)) begin errors++; $display("FAIL stall_map[%0d]: got %h want %h", n, cap_d[n], ref_out(n)); end
      checks++; if (cap_l[n] !== bit'(n == FR - 1)) begin errors++; $display("FAIL stall_last[%0d]: got %b want %b", n, cap_l[n], n == FR - 1); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", stall_viol); end
    checks++; if (acc_viol != 0) begin errors++; $display("FAIL stall_accept_slot: got %0d want 0", acc_viol); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL stall_frame_done: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_back_to_back;
    fill_random(2 * NE);
    stream(2 * NE, 2 * FR, 100, 100);
    checks++; if (cap_d.size() != 2 * FR) begin errors++; $display("FAIL b2b_beats: got %0d want %0d", cap_d.size(), 2 * FR); end
    for (int n = 0; n < cap_d.size(); n++) begin
      checks++; if (cap_d[n] !== ref_out(n)) begin errors++; $display("FAIL b2b_map[%0d]: got %h want %h", n, cap_d[n], ref_out(n)); end
    end
    if (cap_d.size() != 2 * FR) return;
    checks++; if (cap_t[FR] - cap_t[FR-1] != 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", cap_t[FR] - cap_t[FR-1]); end
    checks++; if (cap_t[2*FR-1] - cap_t[0] != 2 * FR - 1) begin errors++; $display("FAIL b2b_span: got %0d want %0d", cap_t[2*FR-1] - cap_t[0], 2 * FR - 1); end
    checks++; if (acc_t[NE] != cap_t[FR-1]) begin errors++; $display("FAIL b2b_next_accept: got cycle %0d want %0d", acc_t[NE], cap_t[FR-1]); end
    checks++; if (!cap_l[FR-1] || !cap_l[2*FR-1]) begin errors++; $display("FAIL b2b_last: got %b %b want 1 1", cap_l[FR-1], cap_l[2*FR-1]); end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL b2b_frame_done: got %0d want 2", fd_cnt); end
    checks++; if (acc_viol != 0) begin errors++; $display("FAIL b2b_accept_slot: got %0d want 0", acc_viol); end
  endtask

  task automatic test_reset_mid;
    int nl = 0;
    fill_random(NE);
    stream(NE, 11 * M + 7, 100, 100);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %b want 1", out_valid); end
    #1 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %b want 0", out_valid); end
    checks++; if (out_data !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL mid_outputs_async: got %h %b want 0 0", out_data, out_last); end
    repeat (2) @(negedge clk);
    rst = 0;
    fill_random(NE);
    pd[0] = 16'hABCD;
    pi[0] = 2'd1;
    stream(NE, FR, 100, 100);
    checks++; if (cap_d.size() != FR) begin errors++; $display("FAIL mid_beats: got %0d want %0d", cap_d.size(), FR); end
    for (int n = 0; n < cap_d.size(); n++) begin
      checks++; if (cap_d[n] !== ref_out(n)) begin errors++; $display("FAIL mid_map[%0d]: got %h want %h", n, cap_d[n], ref_out(n)); end
      if (cap_l[n]) nl++;
    end
    if (cap_d.size() != FR) return;
    checks++; if (cap_d[0] !== 16'h0 || cap_d[1] !== 16'hABCD) begin errors++; $display("FAIL mid_first: got %h %h want 0 abcd", cap_d[0], cap_d[1]); end
    checks++; if (nl != 1 || !cap_l[FR-1]) begin errors++; $display("FAIL mid_last: got count %0d final %b want 1 1", nl, cap_l[FR-1]); end
  endtask

  task automatic test_last_element;
    fill_random(NE);
    pd[NE-1] = 16'hFFFF;
    pi[NE-1] = 2'd3;
    stream(NE, FR, 100, 100);
    checks++; if (cap_d.size() != FR) begin errors++; $display("FAIL last_beats: got %0d want %0d", cap_d.size(), FR); end
    if (cap_d.size() != FR) return;
    checks++; if (cap_d[FR-1] !== 16'hFFFF || !cap_l[FR-1]) begin errors++; $display("FAIL last_27_27: got %h last %b want ffff 1", cap_d[FR-1], cap_l[FR-1]); end
    checks++; if (cap_d[26*M+26] !== 16'h0) begin errors++; $display("FAIL last_26_26: got %h want 0", cap_d[26*M+26]); end
    checks++; if (cap_d[26*M+27] !== 16'h0) begin errors++; $display("FAIL last_26_27: got %h want 0", cap_d[26*M+27]); end
    checks++; if (cap_d[27*M+26] !== 16'h0) begin errors++; $display("FAIL last_27_26: got %h want 0", cap_d[27*M+26]); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_idx_cycle;
    test_random_stall;
    test_back_to_back;
    test_reset_mid;
    test_last_element;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
